mul_share_arbiter: RTL

- Shares one fixed_point_multiplier instance (Q-format, BITSIZE total width, FRAC_BITS fraction bits) among NUM_REQ requesters, e.g. the depthwise and pointwise conv engines.
- Round-robin arbitration, one issue per cycle; the multiplier may be pipelined.
- Tracks in-flight operations with an ID FIFO and routes each result back to its originating requester.
- Sits between the requesters and the multiplier's start_flag/a/b/Mul_result/valid ports.

---
 rtl/mul_share_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined fixed-point multiplier among NUM_REQ requesters.
// Optional watchdog on stalled results: define MUL_SHARE_WATCHDOG_EN.
module mul_share_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int BITSIZE         = 14,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*BITSIZE-1:0] a_flat,
  input  logic [NUM_REQ*BITSIZE-1:0] b_flat,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       mul_start,
  output logic [BITSIZE-1:0]         mul_a,
  output logic [BITSIZE-1:0]         mul_b,
  input  logic [BITSIZE-1:0]         mul_result,
  input  logic                       mul_valid,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [BITSIZE-1:0]         rsp_data,
  output logic                       busy,
  output logic                       err
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_fifo [MAX_OUTSTANDING];
  logic [PW-1:0]      r_wr;
  logic [PW-1:0]      r_rd;
  logic [CW-1:0]      r_count;
  logic               r_mul_start;
  logic [BITSIZE-1:0] r_mul_a;
  logic [BITSIZE-1:0] r_mul_b;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [BITSIZE-1:0] r_rsp_data;
  logic               r_err;

  logic               w_can_issue;
  logic               w_found;
  logic [IDW-1:0]     w_cand;
  logic [IDW-1:0]     w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic [BITSIZE-1:0] w_a_arr [NUM_REQ];
  logic [BITSIZE-1:0] w_b_arr [NUM_REQ];
  logic               w_push;
  logic               w_pop;
  logic               w_spur;
  logic               w_wd_fire;
  logic [NUM_REQ-1:0] w_rsp_onehot;
  logic [PW-1:0]      w_wr_next;
  logic [PW-1:0]      w_rd_next;
  logic [IDW-1:0]     w_ptr_next;

`ifdef MUL_SHARE_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] r_wd;

  // Fires on the edge where the stall counter would reach TIMEOUT.
  assign w_wd_fire = (r_count != '0) && !mul_valid && (r_wd == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd <= '0;
    end else if ((r_count == '0) || mul_valid || w_wd_fire) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + 1'b1;
    end
  end
`else
  assign w_wd_fire = 1'b0;
`endif

  // req/gnt handshake: req is held until gnt; gnt is combinational, one-hot, and the
  // operands are captured on the edge that ends the gnt cycle. A full FIFO still issues
  // when a result retires in the same cycle.
  assign w_can_issue = rst && !w_wd_fire && ((r_count < MAX_CNT) || mul_valid);

  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_a_arr[i] = a_flat[i*BITSIZE +: BITSIZE];
      w_b_arr[i] = b_flat[i*BITSIZE +: BITSIZE];
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = IDW'((int'(r_ptr) + k) % NUM_REQ);
      if (w_can_issue && !w_found && req[w_cand]) begin
        w_found        = 1'b1;
        w_gnt_idx      = w_cand;
        w_gnt[w_cand]  = 1'b1;
      end
    end
  end

  assign w_push       = w_found;
  assign w_pop        = mul_valid && (r_count != '0);
  assign w_spur       = mul_valid && (r_count == '0);
  assign w_rsp_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_fifo[r_rd];
  assign w_wr_next    = (r_wr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_wr + 1'b1;
  assign w_rd_next    = (r_rd == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_rd + 1'b1;
  assign w_ptr_next   = (w_gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr       <= '0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
      r_mul_start <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_fifo[i] <= '0;
    end else begin
      r_mul_start <= w_push;
      if (w_push) begin
        r_mul_a      <= w_a_arr[w_gnt_idx];
        r_mul_b      <= w_b_arr[w_gnt_idx];
        r_fifo[r_wr] <= w_gnt_idx;
        r_wr         <= w_wr_next;
        r_ptr        <= w_ptr_next;
      end
      if (w_pop) begin
        r_rd        <= w_rd_next;
        r_rsp_valid <= w_rsp_onehot;
        r_rsp_data  <= mul_result;
      end else begin
        r_rsp_valid <= '0;
      end
      // Watchdog flush drops every tag; it never coincides with a pop.
      if (w_wd_fire) begin
        r_count <= '0;
        r_rd    <= r_wr;
      end else if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      r_err <= r_err | w_spur | w_wd_fire;
    end
  end

  assign gnt       = w_gnt;
  assign mul_start = r_mul_start;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_count != '0);
  assign err       = r_err;

endmodule
